// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, memory-stage FSM
// states, word/byte widths and the memory request decoder.
package y86_pkg;

  localparam int WORD_W     = 64;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 8;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  function automatic mem_req_t mem_decode(
    input logic [3:0]        icode,
    input logic [WORD_W-1:0] valE,
    input logic [WORD_W-1:0] valA,
    input logic [WORD_W-1:0] valP
  );
    mem_req_t r;
    r = '0;
    unique case (icode)
      IRMMOVQ, IPUSHQ: begin
        r.wr    = 1'b1;
        r.addr  = valE;
        r.wdata = valA;
      end
      ICALL: begin
        r.wr    = 1'b1;
        r.addr  = valE;
        r.wdata = valP;
      end
      IMRMOVQ: begin
        r.rd   = 1'b1;
        r.addr = valE;
      end
      IRET, IPOPQ: begin
        r.rd   = 1'b1;
        r.addr = valA;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_64_if.sv
// Start/done request bundle between execute/PC logic and
// the Y86-64 memory stage.
interface memory_64_if;
  import y86_pkg::*;

  logic              start;
  logic [3:0]        icode;
  logic [WORD_W-1:0] valE;
  logic [WORD_W-1:0] valA;
  logic [WORD_W-1:0] valP;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] valM;
  logic              dmem_error;

  modport master (
    output start, icode, valE, valA, valP,
    input  busy, done, valM, dmem_error
  );

  modport slave (
    input  start, icode, valE, valA, valP,
    output busy, done, valM, dmem_error
  );

endinterface

// File: rtl/dmem_64.sv
// Single-port word-organised data RAM: combinational read,
// synchronous byte-enabled write.
module dmem_64
  import y86_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic [AW-1:0]         i_addr,
  input  logic [WORD_BYTES-1:0] i_be,
  input  logic [WORD_W-1:0]     i_wdata,
  input  logic                  i_we,
  output logic [WORD_W-1:0]     o_rdata
);

  logic [WORD_W-1:0] r_mem [MEM_WORDS];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (i_be[b])
          r_mem[i_addr][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/memory_64.sv
// Y86-64 SEQ memory stage with start/done handshake.
// Define MEM_UNALIGNED_EN to split unaligned quadwords in two accesses.
module memory_64
  import y86_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst,
  memory_64_if.slave   bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [WORD_W:0] LAST_ADDR = (WORD_W+1)'(MEM_WORDS*8-8);

  mem_state_t r_state;
  mem_state_t w_next;

  logic              r_wr;
  logic [AW-1:0]     r_word0;
  logic [2:0]        r_off;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_valM;
  logic              r_err;

  mem_req_t          w_req;
  logic [2:0]        w_off;
  logic              w_access;
  logic              w_fault;
  logic [5:0]        w_sh0;

  logic [AW-1:0]         w_mem_addr;
  logic [WORD_BYTES-1:0] w_mem_be;
  logic [WORD_W-1:0]     w_mem_wd;
  logic                  w_mem_we;
  logic [WORD_W-1:0]     w_mem_rd;

`ifdef MEM_UNALIGNED_EN
  logic [WORD_W-1:0] r_acc;
  logic [2:0]        w_noff;
  logic [5:0]        w_sh1;

  assign w_noff = 3'd0 - r_off;
  assign w_sh1  = {w_noff, 3'b000};
`endif

  assign w_req    = mem_decode(bus.icode, bus.valE, bus.valA, bus.valP);
  assign w_off    = w_req.addr[2:0];
  assign w_access = w_req.rd | w_req.wr;
  assign w_sh0    = {r_off, 3'b000};

  // 65-bit compare so addresses near 2^64 cannot wrap into range
`ifdef MEM_UNALIGNED_EN
  assign w_fault = w_access &&
                   ({1'b0, w_req.addr} > LAST_ADDR);
`else
  assign w_fault = w_access &&
                   (({1'b0, w_req.addr} > LAST_ADDR) ||
                    (w_off != 3'd0));
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.start)
          w_next = (!w_access || w_fault) ? DONE : ACC0;
      end
`ifdef MEM_UNALIGNED_EN
      ACC0: w_next = (r_off == 3'd0) ? DONE : ACC1;
      ACC1: w_next = DONE;
`else
      ACC0: w_next = DONE;
      ACC1: w_next = IDLE;
`endif
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_mem_addr = r_word0;
    w_mem_be   = '0;
    w_mem_wd   = '0;
    w_mem_we   = 1'b0;
    unique case (r_state)
      ACC0: begin
        w_mem_be = 8'hFF << r_off;
        w_mem_wd = r_wdata << w_sh0;
        w_mem_we = r_wr & ~rst;
      end
`ifdef MEM_UNALIGNED_EN
      ACC1: begin
        w_mem_addr = r_word0 + AW'(1);
        w_mem_be   = ~(8'hFF << r_off);
        w_mem_wd   = r_wdata >> w_sh1;
        w_mem_we   = r_wr & ~rst;
      end
`endif
      default: ;
    endcase
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);
  assign bus.valM       = r_valM;
  assign bus.dmem_error = r_err;

  // results land on the edge entering DONE so they are valid with done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_word0 <= '0;
      r_off   <= '0;
      r_wdata <= '0;
      r_valM  <= '0;
      r_err   <= 1'b0;
`ifdef MEM_UNALIGNED_EN
      r_acc   <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_wr    <= w_req.wr;
            r_word0 <= w_req.addr[AW+2:3];
            r_off   <= w_off;
            r_wdata <= w_req.wdata;
            if (!w_access || w_fault) begin
              r_valM <= '0;
              r_err  <= w_fault;
            end
          end
        end
        ACC0: begin
`ifdef MEM_UNALIGNED_EN
          if (r_off == 3'd0) begin
            r_valM <= r_wr ? '0 : w_mem_rd;
            r_err  <= 1'b0;
          end else begin
            r_acc <= w_mem_rd >> w_sh0;
          end
`else
          r_valM <= r_wr ? '0 : w_mem_rd;
          r_err  <= 1'b0;
`endif
        end
`ifdef MEM_UNALIGNED_EN
        ACC1: begin
          r_valM <= r_wr ? '0 : (r_acc | (w_mem_rd << w_sh1));
          r_err  <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  dmem_64 #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_dmem (
    .clk     (clk),
    .i_addr  (w_mem_addr),
    .i_be    (w_mem_be),
    .i_wdata (w_mem_wd),
    .i_we    (w_mem_we),
    .o_rdata (w_mem_rd)
  );

endmodule

// File: tb/tb_memory_64.sv
// Scoreboard bench for memory_64; expectations follow
// MEM_UNALIGNED_EN when it is defined.
module tb_memory_64;
  import y86_pkg::*;

`ifdef MEM_UNALIGNED_EN
  localparam bit UA = 1'b1;
`else
  localparam bit UA = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_64_if bus();

  memory_64 #(.MEM_WORDS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       nm;
    logic [63:0] valM;
    logic        err;
    int          lat;
    int          n;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ndone = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      ndone++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cyc %0d", cyc);
      end else begin
        m_e = q.pop_front();
        chk({m_e.nm, "_valM"}, bus.valM, m_e.valM);
        chk({m_e.nm, "_err"}, 64'(bus.dmem_error), 64'(m_e.err));
        chk({m_e.nm, "_lat"}, 64'(cyc - m_e.n + 1), 64'(m_e.lat));
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] ic,
                       input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, input logic [63:0] xv,
                       input logic xerr, input int lat);
    int t;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.icode = ic;
    bus.valE  = e;
    bus.valA  = a;
    bus.valP  = p;
    q.push_back('{nm, xv, xerr, lat, cyc + 1});
    t = ndone;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 10 && ndone == t; i++) @(posedge clk);
    if (ndone == t) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.icode = '0;
    bus.valE  = '0;
    bus.valA  = '0;
    bus.valP  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_valM", bus.valM, 64'd0);
    chk("rst_err", 64'(bus.dmem_error), 64'd0);
    rst = 1'b0;

    issue("wr10", IRMMOVQ, 64'h10, 64'h1122334455667788, 64'h0,
          64'h0, 1'b0, 2);
    issue("rd10", IMRMOVQ, 64'h10, 64'h0, 64'h0,
          64'h1122334455667788, 1'b0, 2);
    issue("push13", IPUSHQ, 64'h13, 64'hA1A2A3A4A5A6A7A8, 64'h0,
          64'h0, !UA, UA ? 3 : 1);
    issue("rd10b", IMRMOVQ, 64'h10, 64'h0, 64'h0,
          UA ? 64'hA4A5A6A7A8667788 : 64'h1122334455667788, 1'b0, 2);
    issue("rd13", IMRMOVQ, 64'h13, 64'h0, 64'h0,
          UA ? 64'hA1A2A3A4A5A6A7A8 : 64'h0, !UA, UA ? 3 : 1);
    issue("call", ICALL, 64'h7F8, 64'h0, 64'h40,
          64'h0, 1'b0, 2);
    issue("ret", IRET, 64'h0, 64'h7F8, 64'h0,
          64'h40, 1'b0, 2);
    issue("rd7fc", IMRMOVQ, 64'h7FC, 64'h0, 64'h0,
          64'h0, 1'b1, 1);
    issue("rdwrap", IMRMOVQ, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0,
          64'h0, 1'b1, 1);
    issue("popq", IPOPQ, 64'h0, 64'h7F8, 64'h0,
          64'h40, 1'b0, 2);

    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("idle_rst_valM", bus.valM, 64'd0);
    chk("idle_rst_busy", 64'(bus.busy), 64'd0);

    issue("opq", IOPQ, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1);

    // second start lands while the first request sits in DONE
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.icode = IOPQ;
    q.push_back('{"opq_b", 64'h0, 1'b0, 1, cyc + 1});
    t = ndone;
    @(posedge clk); #1;
    chk("busy_in_done", 64'(bus.busy), 64'd1);
    bus.icode = IMRMOVQ;
    bus.valE  = 64'h7FC;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    chk("one_done", 64'(ndone - t), 64'd1);

`ifdef MEM_UNALIGNED_EN
    issue("wr20", IRMMOVQ, 64'h20, 64'h0102030405060708, 64'h0,
          64'h0, 1'b0, 2);
    issue("wr28", IRMMOVQ, 64'h28, 64'h1112131415161718, 64'h0,
          64'h0, 1'b0, 2);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.icode = IPUSHQ;
    bus.valE  = 64'h23;
    bus.valA  = 64'hB1B2B3B4B5B6B7B8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("torn_busy", 64'(bus.busy), 64'd0);
    chk("torn_done", 64'(bus.done), 64'd0);
    chk("torn_valM", bus.valM, 64'd0);
    chk("torn_err", 64'(bus.dmem_error), 64'd0);
    rst = 1'b0;
    issue("rd20", IMRMOVQ, 64'h20, 64'h0, 64'h0,
          64'hB4B5B6B7B8060708, 1'b0, 2);
    issue("rd28", IMRMOVQ, 64'h28, 64'h0, 64'h0,
          64'h1112131415161718, 1'b0, 2);
`endif

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
